// File: rtl/serial_latch_loader_if.sv
// rtl/serial_latch_loader_if.sv - serial input / latch-bank output bundle for serial_latch_loader
//
// Signals:
//   start, sin, sin_valid           : serial source side (driven by master)
//   D, en, busy, done, parity_err   : latch bank / status side (driven by slave)
// Modports:
//   slave  : the loader itself
//   master : the serial source / environment
interface serial_latch_loader_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] D;
    logic             en;
    logic             busy;
    logic             done;
    logic             parity_err;

    modport slave (
        input  start, sin, sin_valid,
        output D, en, busy, done, parity_err
    );

    modport master (
        output start, sin, sin_valid,
        input  D, en, busy, done, parity_err
    );
endinterface

// File: rtl/serial_latch_loader.sv
// rtl/serial_latch_loader.sv - deserialises a serial frame and strobes it into a D-latch bank
//
// Optional feature macro: SERIAL_LATCH_LOADER_PARITY_CHECK_EN
//   undefined : a frame is exactly WIDTH bits, parity_err tied low
//   defined   : a frame is WIDTH data bits plus one even-parity bit; a bad
//               parity bit skips the load and pulses parity_err instead
//
// Parameters:
//   WIDTH        data word width, 2..32
//   HOLD_CYCLES  cycles en is held high per load, 1..15
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   bus.start        begin a frame (sampled only in IDLE)
//   bus.sin          serial data, MSB first
//   bus.sin_valid    sin qualifier, shifting stalls while low
//   bus.D            registered parallel word to the latch bank
//   bus.en           latch enable strobe
//   bus.busy         high whenever not IDLE
//   bus.done         one-cycle pulse after a load
//   bus.parity_err   one-cycle pulse on a rejected frame
module serial_latch_loader #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_latch_loader_if.slave  bus
);

    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int HOLD_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_SETUP,
        S_STROBE,
        S_RELEASE
`ifdef SERIAL_LATCH_LOADER_PARITY_CHECK_EN
        , S_ERR
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   shifted;

    assign shifted = {shreg_q[WIDTH-2:0], bus.sin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            hold_q   <= '0;
            d_q      <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            hold_q   <= hold_d;
            d_q      <= d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        hold_d   = hold_q;
        d_d      = d_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SHIFT;
                    shreg_d  = '0;
                    bitcnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (bus.sin_valid) begin
`ifdef SERIAL_LATCH_LOADER_PARITY_CHECK_EN
                    // After WIDTH data bits the shift register is frozen and the
                    // next valid bit is compared against the data's even parity.
                    if (bitcnt_q == CNT_W'(WIDTH)) begin
                        if ((^shreg_q) == bus.sin) begin
                            d_d     = shreg_q;
                            state_d = S_SETUP;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else begin
                        shreg_d  = shifted;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
`else
                    shreg_d  = shifted;
                    bitcnt_d = bitcnt_q + 1'b1;
                    // D is loaded on the same edge as the last bit so it has a
                    // full SETUP cycle to settle before en rises.
                    if (bitcnt_q == CNT_W'(WIDTH - 1)) begin
                        d_d     = shifted;
                        state_d = S_SETUP;
                    end
`endif
                end
            end
            S_SETUP: begin
                hold_d  = '0;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = S_RELEASE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
`ifdef SERIAL_LATCH_LOADER_PARITY_CHECK_EN
            S_ERR: begin
                state_d = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decode the state register only, so they are glitch-free
    // with respect to the serial inputs.
    assign bus.D    = d_q;
    assign bus.en   = (state_q == S_STROBE);
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_RELEASE);
`ifdef SERIAL_LATCH_LOADER_PARITY_CHECK_EN
    assign bus.parity_err = (state_q == S_ERR);
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_latch_loader.sv
// tb/tb_serial_latch_loader.sv - scoreboard bench for serial_latch_loader (HOLD_CYCLES 1 and 3)
module tb_serial_latch_loader;

    localparam int W    = 8;
    localparam int HMAX = 3;

    logic clk;
    logic rst_n;
    logic start;
    logic sin;
    logic sin_valid;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    serial_latch_loader_if #(.WIDTH(W)) if0 ();
    serial_latch_loader_if #(.WIDTH(W)) if1 ();

    assign if0.start     = start;
    assign if0.sin       = sin;
    assign if0.sin_valid = sin_valid;
    assign if1.start     = start;
    assign if1.sin       = sin;
    assign if1.sin_valid = sin_valid;

    serial_latch_loader #(.WIDTH(W), .HOLD_CYCLES(1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    serial_latch_loader #(.WIDTH(W), .HOLD_CYCLES(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] word;
        int           ld;
        bit           err;
    } exp_t;

    exp_t exp_q[$];

    logic [W-1:0] d_a[2];
    logic         en_a[2], busy_a[2], done_a[2], perr_a[2];

    assign d_a[0] = if0.D;          assign d_a[1] = if1.D;
    assign en_a[0] = if0.en;        assign en_a[1] = if1.en;
    assign busy_a[0] = if0.busy;    assign busy_a[1] = if1.busy;
    assign done_a[0] = if0.done;    assign done_a[1] = if1.done;
    assign perr_a[0] = if0.parity_err; assign perr_a[1] = if1.parity_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int           rd[2];
    int           en_cnt[2];
    int           last_end[2];
    logic [W-1:0] prev_d[2];

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        int   hc;
        int   busy_end;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                prev_d[k]   = '0;
                en_cnt[k]   = 0;
                last_end[k] = -10;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                hc   = (k == 0) ? 1 : 3;
                have = (rd[k] < exp_q.size());
                if (have) e = exp_q[rd[k]];
                else      e = '{word: '0, ld: -100, err: 1'b0};
                busy_end = e.err ? e.ld : e.ld + hc + 1;
                if (cyc == last_end[k] + 1)
                    chk($sformatf("busy_fall[%0d]", k), 32'(busy_a[k]), 32'd0);
                else if (have && cyc >= e.ld && cyc <= busy_end)
                    chk($sformatf("busy_high[%0d]", k), 32'(busy_a[k]), 32'd1);
                if (d_a[k] !== prev_d[k]) begin
                    chk($sformatf("d_change_allowed[%0d]", k), 32'(have && !e.err), 32'd1);
                    chk($sformatf("d_change_cycle[%0d]", k), 32'(cyc), 32'(e.ld));
                    chk($sformatf("d_value[%0d]", k), 32'(d_a[k]), 32'(e.word));
                    prev_d[k] = d_a[k];
                end
                if (en_a[k]) begin
                    if (en_cnt[k] == 0) begin
                        chk($sformatf("en_rise_frame[%0d]", k), 32'(have && !e.err), 32'd1);
                        chk($sformatf("en_rise_cycle[%0d]", k), 32'(cyc), 32'(e.ld + 1));
                    end
                    chk($sformatf("d_during_en[%0d]", k), 32'(d_a[k]), 32'(e.word));
                    en_cnt[k]++;
                end
                if (done_a[k]) begin
                    chk($sformatf("done_frame[%0d]", k), 32'(have && !e.err), 32'd1);
                    chk($sformatf("done_cycle[%0d]", k), 32'(cyc), 32'(e.ld + hc + 1));
                    chk($sformatf("en_len[%0d]", k), 32'(en_cnt[k]), 32'(hc));
                    chk($sformatf("d_at_done[%0d]", k), 32'(d_a[k]), 32'(e.word));
                    rd[k]++;
                    en_cnt[k]   = 0;
                    last_end[k] = cyc;
                end
                if (perr_a[k]) begin
                    chk($sformatf("perr_frame[%0d]", k), 32'(have && e.err), 32'd1);
                    chk($sformatf("perr_cycle[%0d]", k), 32'(cyc), 32'(e.ld));
                    chk($sformatf("en_on_err[%0d]", k), 32'(en_cnt[k]), 32'd0);
                    rd[k]++;
                    en_cnt[k]   = 0;
                    last_end[k] = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sin_valid = 1'($urandom_range(0, 1));
            sin       = 1'($urandom_range(0, 1));
            tick();
        end
        sin_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int nbits, input int stall_at,
                             input int stall_len, input bit rnd);
        logic [W-1:0] wv;
        int ns;
        wv = w;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ns = 0;
            if (i == stall_at) ns = stall_len;
            else if (rnd && $urandom_range(0, 3) == 0) ns = $urandom_range(1, 2);
            if (ns > 0) begin
                sin_valid = 1'b0;
                for (int s = 0; s < ns; s++) begin
                    sin = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            sin       = wv[W-1-i];
            sin_valid = 1'b1;
            tick();
        end
    endtask

    task automatic send_frame(input logic [W-1:0] w, input int stall_at, input int stall_len,
                              input bit rnd, input bit bad_par);
        logic [W-1:0] wv;
        int ones;
        wv = w;
        send_bits(w, W, stall_at, stall_len, rnd);
`ifdef SERIAL_LATCH_LOADER_PARITY_CHECK_EN
        ones = 0;
        for (int i = 0; i < W; i++) ones += int'(wv[i]);
        sin       = 1'(ones % 2) ^ bad_par;
        sin_valid = 1'b1;
        tick();
        exp_q.push_back('{word: w, ld: cyc, err: bad_par});
`else
        ones = 0;
        exp_q.push_back('{word: w, ld: cyc, err: 1'b0});
`endif
        sin_valid = 1'b0;
        sin       = 1'($urandom_range(0, 1));
    endtask

    task automatic finish_frame(input int gap);
        idle_cycles(HMAX + 2 + gap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; sin = 1'b0; sin_valid = 1'b0;
        #2;
        chk("reset_d0", 32'(if0.D), 32'd0);
        chk("reset_en0", 32'(if0.en), 32'd0);
        chk("reset_busy0", 32'(if0.busy), 32'd0);
        chk("reset_done1", 32'(if1.done), 32'd0);
        chk("reset_perr1", 32'(if1.parity_err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        send_frame(8'hA5, -1, 0, 1'b0, 1'b0);
        finish_frame(1);
        send_frame(8'hA5, 4, 3, 1'b0, 1'b0);
        finish_frame(1);

        send_frame(8'h3C, -1, 0, 1'b0, 1'b0);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        idle_cycles(4);
        chk("no_extra_frame0", 32'(if0.busy), 32'd0);
        chk("no_extra_frame1", 32'(if1.busy), 32'd0);

        send_frame(8'hA5, -1, 0, 1'b0, 1'b0);
        finish_frame(1);
        send_bits(8'hFF, 5, -1, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_d0", 32'(if0.D), 32'd0);
        chk("midrst_d1", 32'(if1.D), 32'd0);
        chk("midrst_en1", 32'(if1.en), 32'd0);
        chk("midrst_busy0", 32'(if0.busy), 32'd0);
        chk("midrst_busy1", 32'(if1.busy), 32'd0);
        sin_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(1);
        send_frame(8'h0F, -1, 0, 1'b0, 1'b0);
        finish_frame(1);

        send_frame(8'h12, -1, 0, 1'b0, 1'b0);
        finish_frame(0);
        send_frame(8'h34, -1, 0, 1'b0, 1'b0);
        finish_frame(1);
        chk("b2b_final_d1", 32'(if1.D), 32'h34);

`ifdef SERIAL_LATCH_LOADER_PARITY_CHECK_EN
        send_frame(8'hA5, -1, 0, 1'b0, 1'b0);
        finish_frame(1);
        send_frame(8'h5A, -1, 0, 1'b0, 1'b0);
        finish_frame(1);
        send_frame(8'hA5, -1, 0, 1'b0, 1'b1);
        finish_frame(1);
        chk("perr_keeps_d0", 32'(if0.D), 32'h5A);
`endif

        for (int f = 0; f < 16; f++) begin
            send_frame(8'($urandom_range(0, 255)), -1, 0, 1'b1,
                       ($urandom_range(0, 3) == 0));
            finish_frame($urandom_range(0, 2));
        end

        idle_cycles(10);
        chk("drained0", 32'(rd[0]), 32'(exp_q.size()));
        chk("drained1", 32'(rd[1]), 32'(exp_q.size()));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
